// File: rtl/io_input_pkg.sv
// Shared definitions for the input-side I/O responder.
//   ch_state_t     : per-channel FSM state (IDLE, WAIT, DONE)
//   CH1_SEL/CH2_SEL: io_addr codes selecting channel 1 / channel 2
//   DEB_CYCLES_DEF : default debounce hold time in clock cycles
package io_input_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } ch_state_t;

    localparam logic [1:0] CH1_SEL = 2'b01;
    localparam logic [1:0] CH2_SEL = 2'b10;

    localparam int unsigned DEB_CYCLES_DEF = 100000;

endpackage

// File: rtl/io_debounce.sv
// Button debouncer: 2-FF synchroniser, stability counter, stable level and
// a one-cycle pulse on the stable 0->1 transition.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_btn   : raw (asynchronous, bouncing) button level
//   o_press : one-cycle pulse when the debounced level rises
module io_debounce
    import io_input_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_flip;

    // The synced level has differed from the stable one long enough to accept it.
    assign w_flip = (r_sync2 != r_stable) && (r_cnt == CNT_MAX);

    always_comb begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_sync2 == r_stable || w_flip) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_cnt   <= w_cnt_next;
            if (w_flip) begin
                r_stable <= r_sync2;
            end
            // Registered together with the stable level, so it is the rising-edge pulse.
            r_press <= w_flip & r_sync2;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/io_input_commit.sv
// Input-side I/O responder. A CPU load from an input channel holds that
// channel's commit high (blocking register write-back) until the channel's
// confirm button is pressed; the switch value is then captured into io_rdata
// and commit drops for exactly one cycle so the write lands.
// Ports:
//   clock    : system clock, rising edge
//   reset    : asynchronous active-low reset
//   io_read  : CPU load to the input region, held for the stalled instruction
//   io_addr  : channel select (01 = channel 1, 10 = channel 2, else none)
//   switch   : raw board switches, sampled only at capture
//   btn1/2   : raw confirm buttons for channel 1 / channel 2
//   commit1/2: high while the channel's read is pending
//   io_rdata : captured switch value, zero-extended, held until next capture
// Optional feature macro: IO_PRESS_LATCH_EN (remember a press made while
// idle so the following read completes without stalling).
module io_input_commit
    import io_input_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_read,
    input  logic [1:0]        io_addr,
    input  logic [DATA_W-1:0] switch,
    input  logic              btn1,
    input  logic              btn2,
    output logic              commit1,
    output logic              commit2,
    output logic [31:0]       io_rdata
);

    logic [1:0]  w_btn;
    logic [1:0]  w_press;
    logic [1:0]  w_cap;
    logic [1:0]  w_commit;
    logic [31:0] r_rdata;

    assign w_btn = {btn2, btn1};

    for (genvar g = 0; g < 2; g++) begin : g_ch
        localparam logic [1:0] SEL = (g == 0) ? CH1_SEL : CH2_SEL;

        ch_state_t r_state;
        ch_state_t w_state_next;
        logic      w_sel;
        logic      w_early;
        logic      w_flag;
        logic      w_pend;
        logic      w_cap_ch;

        io_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .i_clk   (clock),
            .i_rst_n (reset),
            .i_btn   (w_btn[g]),
            .o_press (w_press[g])
        );

        assign w_sel = io_read && (io_addr == SEL);

`ifdef IO_PRESS_LATCH_EN
        logic r_flag;
        logic w_flag_next;

        // Set by a press while idle; consumed by the next read of this channel.
        always_comb begin
            w_flag_next = r_flag;
            if (r_state == IDLE) begin
                w_flag_next = w_sel ? 1'b0 : (r_flag | w_press[g]);
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_flag <= 1'b0;
            end else begin
                r_flag <= w_flag_next;
            end
        end

        assign w_flag  = r_flag;
        assign w_early = r_flag | w_press[g];
`else
        assign w_flag  = 1'b0;
        assign w_early = 1'b0;
`endif

        always_comb begin
            w_state_next = r_state;
            w_pend       = 1'b0;
            w_cap_ch     = 1'b0;
            case (r_state)
                IDLE: begin
                    // Stall in the very cycle the load appears so no stale write occurs.
                    w_pend = w_sel && !w_flag;
                    if (w_sel) begin
                        if (w_early) begin
                            w_state_next = DONE;
                            w_cap_ch     = 1'b1;
                        end else begin
                            w_state_next = WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Selection is latched at entry; io_addr is ignored here.
                    w_pend = 1'b1;
                    if (w_press[g]) begin
                        w_state_next = DONE;
                        w_cap_ch     = 1'b1;
                    end
                end
                DONE: begin
                    w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_state <= IDLE;
            end else begin
                r_state <= w_state_next;
            end
        end

        // Gated by reset so commit is low while reset is held, even with a read present.
        assign w_commit[g] = reset & w_pend;
        assign w_cap[g]    = w_cap_ch;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (|w_cap) begin
            r_rdata <= 32'(switch);
        end
    end

    assign commit1  = w_commit[0];
    assign commit2  = w_commit[1];
    assign io_rdata = r_rdata;

endmodule

// File: tb/tb_io_input_commit.sv
module tb_io_input_commit;

    localparam int DEB = 4;

    logic        clock;
    logic        reset;
    logic        io_read;
    logic [1:0]  io_addr;
    logic [15:0] switch;
    logic        btn1;
    logic        btn2;
    logic        commit1;
    logic        commit2;
    logic [31:0] io_rdata;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       rd;
        logic [1:0] addr;
        logic       c1;
        logic       c2;
    } vec_t;

    vec_t vecs[6];

    io_input_commit #(
        .DATA_W     (16),
        .DEB_CYCLES (DEB)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .io_read  (io_read),
        .io_addr  (io_addr),
        .switch   (switch),
        .btn1     (btn1),
        .btn2     (btn2),
        .commit1  (commit1),
        .commit2  (commit2),
        .io_rdata (io_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Count edges until the channel's commit drops; a missing drop shows as 40.
    task automatic wait_done(input int ch, input int exp_lat, input string name);
        int n;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (((ch == 1) ? commit1 : commit2) == 1'b0) break;
        end
        chk(name, n, exp_lat);
    endtask

    initial begin
        logic ok;

        vecs[0] = '{1'b1, 2'b00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 2'b01, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 2'b10, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 2'b11, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 2'b01, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 2'b10, 1'b0, 1'b0};

        // Reset held with a channel-1 read present.
        reset   = 1'b0;
        io_read = 1'b1;
        io_addr = 2'b01;
        switch  = 16'h0000;
        btn1    = 1'b0;
        btn2    = 1'b0;
        repeat (3) tick();
        chk("rst_commit1", commit1, 0);
        chk("rst_commit2", commit2, 0);
        chk("rst_rdata", io_rdata, 0);
        reset = 1'b1;
        #1;
        chk("rel_commit1", commit1, 1);
        chk("rel_commit2", commit2, 0);
        io_read = 1'b0;
        tick();

        // Address decode in IDLE, checked combinationally before any edge.
        for (int i = 0; i < 6; i++) begin
            switch  = 16'h1111 * 16'(i + 1);
            io_read = vecs[i].rd;
            io_addr = vecs[i].addr;
            #1;
            chk($sformatf("dec%0d_c1", i), commit1, vecs[i].c1);
            chk($sformatf("dec%0d_c2", i), commit2, vecs[i].c2);
            io_read = 1'b0;
            tick();
        end
        io_read = 1'b1;
        io_addr = 2'b11;
        repeat (2) tick();
        chk("addr11_c1", commit1, 0);
        chk("addr11_rdata", io_rdata, 0);
        io_read = 1'b0;
        tick();

        // Basic read on channel 1.
        io_read = 1'b1;
        io_addr = 2'b01;
        switch  = 16'hA5A5;
        tick();
        btn1 = 1'b1;
        wait_done(1, DEB + 3, "basic_latency");
        chk("basic_rdata", io_rdata, 32'h0000A5A5);
        chk("basic_commit2", commit2, 0);
        io_read = 1'b0;
        tick();
        chk("basic_idle_c1", commit1, 0);
        io_read = 1'b1;
        #1;
        chk("basic_back_idle", commit1, 1);
        io_read = 1'b0;
        btn1 = 1'b0;
        repeat (DEB + 4) tick();

        // Bouncing button must not complete the read.
        io_read = 1'b1;
        io_addr = 2'b01;
        switch  = 16'h0F0F;
        tick();
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            btn1 = ((i >> 1) & 1) == 1;
            tick();
            if (commit1 !== 1'b1) ok = 1'b0;
        end
        chk("bounce_stall", ok, 1);
        chk("bounce_rdata", io_rdata, 32'h0000A5A5);
        btn1 = 1'b1;
        wait_done(1, DEB + 3, "bounce_latency");
        chk("bounce_cap", io_rdata, 32'h00000F0F);
        io_read = 1'b0;
        tick();
        btn1 = 1'b0;
        repeat (DEB + 4) tick();

        // Channel 2 waits; channel-1 press and an address change do nothing.
        io_read = 1'b1;
        io_addr = 2'b10;
        switch  = 16'h1234;
        tick();
        btn1 = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) io_addr = 2'b00;
            if (i == 9) io_addr = 2'b10;
            if (i == 10) btn1 = 1'b0;
            tick();
            if (commit2 !== 1'b1 || commit1 !== 1'b0) ok = 1'b0;
        end
        chk("cross_stall", ok, 1);
        chk("cross_rdata", io_rdata, 32'h00000F0F);
        btn2 = 1'b1;
        wait_done(2, DEB + 3, "cross_latency");
        chk("cross_cap", io_rdata, 32'h00001234);

        // Back-to-back load from channel 2: held button must not count again.
        switch = 16'h4321;
        tick();
        chk("b2b_restall", commit2, 1);
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (commit2 !== 1'b1) ok = 1'b0;
        end
        chk("b2b_no_reuse", ok, 1);
        chk("b2b_rdata_hold", io_rdata, 32'h00001234);
        btn2 = 1'b0;
        repeat (DEB + 4) tick();
        btn2 = 1'b1;
        wait_done(2, DEB + 3, "b2b_latency");
        chk("b2b_cap", io_rdata, 32'h00004321);
        io_read = 1'b0;
        tick();
        btn2 = 1'b0;
        repeat (DEB + 4) tick();

        // Press while idle, then read channel 1.
        switch = 16'h5A5A;
        btn1 = 1'b1;
        repeat (DEB + 4) tick();
        btn1 = 1'b0;
        repeat (DEB + 4) tick();
        io_read = 1'b1;
        io_addr = 2'b01;
        #1;
`ifdef IO_PRESS_LATCH_EN
        chk("latch_c1_idle", commit1, 0);
        tick();
        chk("latch_c1_done", commit1, 0);
        chk("latch_rdata", io_rdata, 32'h00005A5A);
        io_read = 1'b0;
        tick();
        io_read = 1'b1;
        #1;
        chk("latch_flag_clr", commit1, 1);
`else
        chk("idle_press_c1", commit1, 1);
        tick();
        chk("idle_press_wait", commit1, 1);
        chk("idle_press_rdata", io_rdata, 32'h00004321);
`endif

        // Reset while channel 1 waits.
        tick();
        chk("pre_rst_wait", commit1, 1);
        reset = 1'b0;
        #1;
        chk("rst_wait_c1", commit1, 0);
        chk("rst_wait_rdata", io_rdata, 0);
        io_read = 1'b0;
        reset   = 1'b1;
        #1;
        chk("rst_wait_idle", commit1, 0);
        io_read = 1'b1;
        #1;
        chk("rst_wait_reread", commit1, 1);
        io_read = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/io_input_commit.md
Name: io_input_commit

Overview:
- Input-side I/O responder that produces the commit1/commit2 stall signals and the load data consumed by the decode/register-file write-back path.
- When the CPU issues a load from an input channel, the block holds that channel's commit high, so the register write is blocked, until the user presses that channel's confirm button.
- On the press it latches the switch value as load data and drops commit for exactly one cycle, so the write lands.
- Sits between board switches/buttons and the CPU memory/IO mux.

Parameters:
DATA_W, 16, width of switch input; zero-extended to 32 on io_rdata
DEB_CYCLES, 100000, clock cycles a raw button level must hold stable before the debounced level changes (minimum 2)

Ports:
clock  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately)
io_read  input  1  CPU load to I/O input region; held high for the whole stalled instruction
io_addr  input  2  channel select: 2'b01 = channel 1, 2'b10 = channel 2; other codes select nothing
switch  input  DATA_W  raw board switches; sampled only at capture
btn1  input  1  raw confirm button, channel 1
btn2  input  1  raw confirm button, channel 2
commit1  output  1  high = channel 1 read pending; write-back must not occur
commit2  output  1  high = channel 2 read pending
io_rdata  output  32  captured input value, valid in DONE cycle and held until next capture

Behaviour:
- Reset (reset==0, asynchronous):
  - Both channel FSMs go to IDLE; io_rdata=0; debounce counters=0; synchronisers and stable levels=0.
  - commit1=commit2=0.
- Debounce, per button:
  - 2-FF synchroniser, then counter.
  - Counter clears whenever the synced level equals the stable level; otherwise it increments.
  - When the counter reaches DEB_CYCLES-1, the stable level takes the synced level and the counter clears.
  - press_N is a 1-cycle pulse on the stable 0->1 edge.
  - Latency from clean raw edge to press_N: DEB_CYCLES+2 cycles.
- Channel FSM, per channel N; states IDLE, WAIT, DONE:
  - IDLE -> WAIT when io_read && io_addr selects N.
  - WAIT -> DONE on press_N. Same edge: io_rdata <= {zero-pad, switch}.
  - DONE -> IDLE unconditionally after one cycle.
- commitN is combinational: (state==WAIT) || (state==IDLE && io_read && sel_N).
  - It asserts in the same cycle the load appears, so the first edge never writes stale data.
  - commitN=0 in DONE; the CPU write-back occurs on that edge.
- Back-to-back reads of the same channel: the next IDLE cycle with io_read re-asserts commit and requires a new press. A press is never reused.
- Press while IDLE or DONE: ignored (see Optional Feature).
- press_M while channel N waits (M≠N): no effect on N.
- io_addr 2'b00/2'b11 with io_read: no channel selected; commits stay 0; io_rdata unchanged.
- Only one channel can be in WAIT, because the CPU issues one load at a time. If io_addr changes while in WAIT, the FSM stays in WAIT; the selection is latched at entry.
- Reset during WAIT: commit drops asynchronously, state returns to IDLE, the captured value is lost.

Optional Feature:
Macro IO_PRESS_LATCH_EN.
- Defined:
  - Each channel has a 1-bit pending flag, set by press_N while in IDLE and cleared on reset.
  - IDLE with read and flag=1: go directly to DONE, capture switch, clear the flag, commitN stays 0. Zero-stall read.
  - A press in WAIT behaves as without the macro; the flag is not set.
- Undefined: no flag; IDLE presses are discarded as above.

Decomposition:
- Package io_input_pkg holds:
  - state encoding localparams IDLE=2'd0, WAIT=2'd1, DONE=2'd2
  - channel codes CH1_SEL=2'b01, CH2_SEL=2'b10
  - DEB_CYCLES default
- Sub-module io_debounce (synchroniser, counter, stable level, rising-edge pulse) is instantiated twice. Channel FSMs stay inline, generated per channel.

Test Plan:
- Bench uses DEB_CYCLES=4.
- Reset: hold reset=0 with io_read=1, io_addr=01 -> commit1=commit2=0, io_rdata=0; release -> commit1=1 same cycle.
- Basic read: io_read=1, io_addr=01, switch=16'hA5A5; btn1 high 8 cycles -> commit1 high until press edge, one DONE cycle with commit1=0 and io_rdata=32'h0000A5A5, then IDLE.
- Bounce: btn1 toggles every 2 cycles for 10 cycles -> no press, commit1 stays 1; then stable high -> press after DEB_CYCLES+2 cycles.
- Cross-channel: channel 2 waiting, btn1 pressed -> commit2 stays 1, io_rdata unchanged; btn2 pressed -> capture.
- Back-to-back reads: two consecutive loads from 10 -> second load re-stalls; single press only completes the first.
- Reset mid-WAIT, plus macro run: reset pulsed in WAIT -> commit1 drops at once, state IDLE. With IO_PRESS_LATCH_EN, press btn1 in IDLE then read 01 -> commit1 never asserted, io_rdata=switch.
